// File: rtl/npc_gpr_wb_ctrl_if.sv
// Writeback request channel into the GPR write-port controller.
// A source holds valid/rd/data stable until it samples ready high.
interface npc_gpr_wb_ctrl_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            valid;
    logic            ready;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;

    modport master (output valid, output rd, output data, input ready);
    modport slave  (input valid, input rd, input data, output ready);
endinterface

// File: rtl/npc_gpr_wb_ctrl.sv
// GPR write-port arbiter (EXU vs LSU, round-robin on ties), registered write
// toward the register file, and the pending-write scoreboard driving issue stalls.
module npc_gpr_wb_ctrl #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    npc_gpr_wb_ctrl_if.slave     exu_wb,
    npc_gpr_wb_ctrl_if.slave     lsu_wb,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [AW-1:0]        iss_rs1,
    input  logic [AW-1:0]        iss_rs2,
    output logic                 iss_stall,
    output logic                 gpr_wen,
    output logic [AW-1:0]        gpr_waddr,
    output logic [XLEN-1:0]      gpr_wdata,
    output logic [(1<<AW)-1:0]   busy_vec,
    output logic                 sb_err
);
    localparam int NREG = 1 << AW;

    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    src_e            last_grant;
    logic            acc;
    src_e            acc_src;
    logic [AW-1:0]   acc_rd;
    logic [XLEN-1:0] acc_data;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            rd_hit;
    logic            iss_fire;
    logic            commit_err;
    logic [NREG-1:0] busy_next;

    // Ready is withheld during reset so nothing can be accepted and then lost.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first; a path
        // that leaves one unassigned would infer a latch.
        exu_wb.ready = 1'b0;
        lsu_wb.ready = 1'b0;
        if (rst) begin
            if (exu_wb.valid && (!lsu_wb.valid || last_grant == SRC_LSU)) begin
                exu_wb.ready = 1'b1;
            end else if (lsu_wb.valid) begin
                lsu_wb.ready = 1'b1;
            end
        end
    end

    assign acc      = exu_wb.ready | lsu_wb.ready;
    assign acc_src  = exu_wb.ready ? SRC_EXU : SRC_LSU;
    assign acc_rd   = exu_wb.ready ? exu_wb.rd   : lsu_wb.rd;
    assign acc_data = exu_wb.ready ? exu_wb.data : lsu_wb.data;

    // Index 0 never names a real destination or dependency.
    assign rs1_hit   = (iss_rs1 != '0) && busy_vec[iss_rs1];
    assign rs2_hit   = (iss_rs2 != '0) && busy_vec[iss_rs2];
    assign rd_hit    = (iss_rd  != '0) && busy_vec[iss_rd];
    assign iss_stall = rst && iss_valid && (rs1_hit || rs2_hit || rd_hit);
    assign iss_fire  = iss_valid && !iss_stall && (iss_rd != '0);

    assign commit_err = gpr_wen && !busy_vec[gpr_waddr];

    // Clear on commit, then set on issue so a same-index set wins.
    always_comb begin
        busy_next = busy_vec;
        if (gpr_wen) begin
            busy_next[gpr_waddr] = 1'b0;
        end
        if (iss_fire) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= SRC_LSU;
            gpr_wen    <= 1'b0;
            gpr_waddr  <= '0;
            gpr_wdata  <= '0;
            busy_vec   <= '0;
            sb_err     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            busy_vec <= busy_next;
            gpr_wen  <= acc && (acc_rd != '0);
            if (acc) begin
                last_grant <= acc_src;
            end
            // Address/data hold across idle cycles and x0 writes.
            if (acc && (acc_rd != '0)) begin
                gpr_waddr <= acc_rd;
                gpr_wdata <= acc_data;
            end
            if (commit_err) begin
                sb_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_npc_gpr_wb_ctrl.sv
// Directed testbench for npc_gpr_wb_ctrl: reset, arbitration, write timing,
// scoreboard hazards and the sticky protocol-error flag.
module tb_npc_gpr_wb_ctrl;
    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic        iss_stall;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [31:0] busy_vec;
    logic        sb_err;

    int errors = 0;
    int checks = 0;

    npc_gpr_wb_ctrl_if #(.XLEN(32), .AW(5)) exu_wb ();
    npc_gpr_wb_ctrl_if #(.XLEN(32), .AW(5)) lsu_wb ();

    npc_gpr_wb_ctrl #(.XLEN(32), .AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .exu_wb    (exu_wb),
        .lsu_wb    (lsu_wb),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_stall (iss_stall),
        .gpr_wen   (gpr_wen),
        .gpr_waddr (gpr_waddr),
        .gpr_wdata (gpr_wdata),
        .busy_vec  (busy_vec),
        .sb_err    (sb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exu_wb.valid = 1'b0;
        exu_wb.rd    = '0;
        exu_wb.data  = '0;
        lsu_wb.valid = 1'b0;
        lsu_wb.rd    = '0;
        lsu_wb.data  = '0;
        iss_valid    = 1'b0;
        iss_rd       = '0;
        iss_rs1      = '0;
        iss_rs2      = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        exu_wb.valid = 1'b1; exu_wb.rd = 5'd3; exu_wb.data = 32'h3333_3333;
        lsu_wb.valid = 1'b1; lsu_wb.rd = 5'd4; lsu_wb.data = 32'h4444_4444;
        iss_valid = 1'b1; iss_rd = 5'd6; iss_rs1 = 5'd6;
        cyc();
        cyc();
        checks++;
        if (exu_wb.ready !== 1'b0 || lsu_wb.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got exu=%0b lsu=%0b want 0/0", exu_wb.ready, lsu_wb.ready);
        end
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %0b want 0", iss_stall);
        end
        checks++;
        if (gpr_wen !== 1'b0 || gpr_waddr !== 5'd0 || gpr_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_gpr: got wen=%0b addr=%0d data=%h want 0/0/0", gpr_wen, gpr_waddr, gpr_wdata);
        end
        checks++;
        if (busy_vec !== 32'd0 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_sb: got busy=%h err=%0b want 0/0", busy_vec, sb_err);
        end
        idle_inputs();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset_mid();
        iss_valid = 1'b1; iss_rd = 5'd5;
        cyc();
        iss_valid = 1'b0; iss_rd = '0;
        checks++;
        if (busy_vec !== 32'h0000_0020) begin
            errors++;
            $display("FAIL rstmid_busy_set: got %h want 00000020", busy_vec);
        end
        exu_wb.valid = 1'b1; exu_wb.rd = 5'd5; exu_wb.data = 32'h5555_5555;
        #1;
        checks++;
        if (exu_wb.ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready_pre: got %0b want 1", exu_wb.ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (exu_wb.ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready_rst: got %0b want 0", exu_wb.ready);
        end
        cyc();
        checks++;
        if (gpr_wen !== 1'b0 || busy_vec !== 32'd0 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: got wen=%0b busy=%h err=%0b want 0/0/0", gpr_wen, busy_vec, sb_err);
        end
        idle_inputs();
        cyc();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_single_exu();
        iss_valid = 1'b1; iss_rd = 5'd3;
        cyc();
        iss_valid = 1'b0; iss_rd = '0;
        exu_wb.valid = 1'b1; exu_wb.rd = 5'd3; exu_wb.data = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (exu_wb.ready !== 1'b1 || lsu_wb.ready !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got exu=%0b lsu=%0b want 1/0", exu_wb.ready, lsu_wb.ready);
        end
        cyc();
        exu_wb.valid = 1'b0;
        checks++;
        if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd3 || gpr_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_write: got wen=%0b addr=%0d data=%h want 1/3/deadbeef", gpr_wen, gpr_waddr, gpr_wdata);
        end
        checks++;
        if (busy_vec !== 32'h0000_0008) begin
            errors++;
            $display("FAIL single_busy_hold: got %h want 00000008", busy_vec);
        end
        cyc();
        checks++;
        if (busy_vec !== 32'd0 || gpr_wen !== 1'b0 || gpr_waddr !== 5'd3 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL single_after: got busy=%h wen=%0b addr=%0d err=%0b want 0/0/3/0", busy_vec, gpr_wen, gpr_waddr, sb_err);
        end
    endtask

    task automatic test_tie();
        do_reset();
        iss_valid = 1'b1; iss_rd = 5'd1;
        exu_wb.valid = 1'b1; exu_wb.rd = 5'd1; exu_wb.data = 32'h11;
        lsu_wb.valid = 1'b1; lsu_wb.rd = 5'd2; lsu_wb.data = 32'h22;
        #1;
        checks++;
        if (exu_wb.ready !== 1'b1 || lsu_wb.ready !== 1'b0) begin
            errors++;
            $display("FAIL tie1_grant_exu: got exu=%0b lsu=%0b want 1/0", exu_wb.ready, lsu_wb.ready);
        end
        cyc();
        exu_wb.valid = 1'b0;
        iss_rd = 5'd2;
        #1;
        checks++;
        if (lsu_wb.ready !== 1'b1 || gpr_wen !== 1'b1 || gpr_waddr !== 5'd1 || gpr_wdata !== 32'h11) begin
            errors++;
            $display("FAIL tie1_write_1: got lrdy=%0b wen=%0b addr=%0d data=%h want 1/1/1/11", lsu_wb.ready, gpr_wen, gpr_waddr, gpr_wdata);
        end
        cyc();
        lsu_wb.valid = 1'b0;
        iss_valid = 1'b0; iss_rd = '0;
        checks++;
        if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd2 || gpr_wdata !== 32'h22 || busy_vec !== 32'h4) begin
            errors++;
            $display("FAIL tie1_write_2: got wen=%0b addr=%0d data=%h busy=%h want 1/2/22/4", gpr_wen, gpr_waddr, gpr_wdata, busy_vec);
        end
        cyc();
        checks++;
        if (busy_vec !== 32'd0 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL tie1_drain: got busy=%h err=%0b want 0/0", busy_vec, sb_err);
        end
        // Lone EXU x0 write moves the pointer to EXU, so the next tie goes to LSU.
        exu_wb.valid = 1'b1; exu_wb.rd = 5'd0; exu_wb.data = 32'h1;
        cyc();
        lsu_wb.valid = 1'b1; lsu_wb.rd = 5'd0; lsu_wb.data = 32'h2;
        #1;
        checks++;
        if (lsu_wb.ready !== 1'b1 || exu_wb.ready !== 1'b0) begin
            errors++;
            $display("FAIL tie2_grant_lsu: got exu=%0b lsu=%0b want 0/1", exu_wb.ready, lsu_wb.ready);
        end
        checks++;
        if (gpr_wen !== 1'b0) begin
            errors++;
            $display("FAIL x0_exu_nowrite: got wen=%0b want 0", gpr_wen);
        end
        cyc();
        lsu_wb.valid = 1'b0;
        #1;
        checks++;
        if (exu_wb.ready !== 1'b1 || gpr_wen !== 1'b0) begin
            errors++;
            $display("FAIL tie2_exu_next: got erdy=%0b wen=%0b want 1/0", exu_wb.ready, gpr_wen);
        end
        cyc();
        exu_wb.valid = 1'b0;
        checks++;
        if (gpr_wen !== 1'b0 || gpr_waddr !== 5'd2 || gpr_wdata !== 32'h22) begin
            errors++;
            $display("FAIL x0_hold: got wen=%0b addr=%0d data=%h want 0/2/22", gpr_wen, gpr_waddr, gpr_wdata);
        end
    endtask

    task automatic test_raw();
        iss_valid = 1'b1; iss_rd = 5'd7;
        cyc();
        iss_rd = 5'd0; iss_rs1 = 5'd7; iss_rs2 = 5'd0;
        #1;
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL raw_stall_pending: got %0b want 1", iss_stall);
        end
        cyc();
        lsu_wb.valid = 1'b1; lsu_wb.rd = 5'd7; lsu_wb.data = 32'h77;
        #1;
        checks++;
        if (iss_stall !== 1'b1 || lsu_wb.ready !== 1'b1) begin
            errors++;
            $display("FAIL raw_stall_accept: got stall=%0b lrdy=%0b want 1/1", iss_stall, lsu_wb.ready);
        end
        cyc();
        lsu_wb.valid = 1'b0;
        #1;
        checks++;
        if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd7 || iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL raw_stall_commit: got wen=%0b addr=%0d stall=%0b want 1/7/1", gpr_wen, gpr_waddr, iss_stall);
        end
        cyc();
        checks++;
        if (iss_stall !== 1'b0 || busy_vec !== 32'd0) begin
            errors++;
            $display("FAIL raw_release: got stall=%0b busy=%h want 0/0", iss_stall, busy_vec);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_waw_x0();
        iss_valid = 1'b1; iss_rd = 5'd9;
        cyc();
        #1;
        checks++;
        if (iss_stall !== 1'b1) begin
            errors++;
            $display("FAIL waw_stall: got %0b want 1", iss_stall);
        end
        iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_nostall: got %0b want 0", iss_stall);
        end
        iss_valid = 1'b0; iss_rd = 5'd9; iss_rs2 = 5'd9;
        #1;
        checks++;
        if (iss_stall !== 1'b0) begin
            errors++;
            $display("FAIL novalid_nostall: got %0b want 0", iss_stall);
        end
        iss_valid = 1'b1; iss_rd = 5'd0; iss_rs2 = 5'd0;
        exu_wb.valid = 1'b1; exu_wb.rd = 5'd9; exu_wb.data = 32'h99;
        cyc();
        idle_inputs();
        checks++;
        if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd9 || busy_vec !== 32'h0000_0200) begin
            errors++;
            $display("FAIL waw_write: got wen=%0b addr=%0d busy=%h want 1/9/00000200", gpr_wen, gpr_waddr, busy_vec);
        end
        cyc();
        checks++;
        if (busy_vec !== 32'd0 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL waw_drain: got busy=%h err=%0b want 0/0", busy_vec, sb_err);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 10; i <= 12; i++) begin
            iss_valid = 1'b1; iss_rd = 5'(i);
            cyc();
        end
        iss_valid = 1'b0; iss_rd = '0;
        checks++;
        if (busy_vec !== 32'h0000_1C00) begin
            errors++;
            $display("FAIL b2b_busy: got %h want 00001c00", busy_vec);
        end
        for (int i = 10; i <= 12; i++) begin
            exu_wb.valid = 1'b1; exu_wb.rd = 5'(i); exu_wb.data = 32'hA000_0000 + 32'(i);
            #1;
            checks++;
            if (exu_wb.ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d: got %0b want 1", i, exu_wb.ready);
            end
            cyc();
            checks++;
            if (gpr_wen !== 1'b1 || gpr_waddr !== 5'(i) || gpr_wdata !== 32'hA000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL b2b_write_%0d: got wen=%0b addr=%0d data=%h", i, gpr_wen, gpr_waddr, gpr_wdata);
            end
            if (i == 11) begin
                checks++;
                if (busy_vec !== 32'h0000_1800) begin
                    errors++;
                    $display("FAIL b2b_busy_mid: got %h want 00001800", busy_vec);
                end
            end
        end
        exu_wb.valid = 1'b0;
        cyc();
        checks++;
        if (gpr_wen !== 1'b0 || busy_vec !== 32'd0 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got wen=%0b busy=%h err=%0b want 0/0/0", gpr_wen, busy_vec, sb_err);
        end
    endtask

    task automatic test_err();
        exu_wb.valid = 1'b1; exu_wb.rd = 5'd4; exu_wb.data = 32'h44;
        cyc();
        exu_wb.valid = 1'b0;
        checks++;
        if (gpr_wen !== 1'b1 || gpr_waddr !== 5'd4 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL err_write: got wen=%0b addr=%0d err=%0b want 1/4/0", gpr_wen, gpr_waddr, sb_err);
        end
        cyc();
        checks++;
        if (sb_err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %0b want 1", sb_err);
        end
        repeat (3) cyc();
        checks++;
        if (sb_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %0b want 1", sb_err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sb_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %0b want 0", sb_err);
        end
        cyc();
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_reset_mid();
        test_single_exu();
        test_tie();
        test_raw();
        test_waw_x0();
        test_back_to_back();
        test_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
